// File: rtl/rom_dl_ctrl.sv
// rom_dl_ctrl: buffers HPS ioctl ROM writes through a small FIFO into the
// core's download port, and sequences the core reset around downloads.
// The optional running checksum output (dl_sum) is built only when the
// DL_CHECKSUM_EN macro is defined.
module rom_dl_ctrl #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned ROM_SIZE    = 40960,
  parameter int unsigned HOLD_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        rst_req,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic        dn_busy,
  output logic        dn_wr,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        core_reset,
  output logic        overflow,
  output logic        addr_err
`ifdef DL_CHECKSUM_EN
  ,
  output logic [7:0]  dl_sum
`endif
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned ENTRY_W = 24;

  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  WAIT_C  = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_C  = HOLD_W'(HOLD_CYCLES);
  localparam logic [24:0]       ROM_C   = 25'(ROM_SIZE);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_RUN   = 3'd1,
    S_LOAD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD2 = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic                load_entry_c;

  logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic                dn_wr_q, dn_wr_d;
  logic [15:0]         dn_addr_q, dn_addr_d;
  logic [7:0]          dn_data_q, dn_data_d;
  logic                core_reset_q, core_reset_d;
  logic                overflow_q, overflow_d;
  logic                addr_err_q, addr_err_d;

  logic                in_range_c, fifo_full_c, fifo_empty_c;
  logic                push_c, pop_c, drop_range_c, drop_full_c;

  // Accept/drop decisions for this cycle's write and pop
  assign in_range_c   = (ioctl_addr < ROM_C);
  assign fifo_full_c  = (count_q == DEPTH_C);
  assign fifo_empty_c = (count_q == '0);
  assign pop_c        = !fifo_empty_c && !dn_busy;
  assign push_c       = ioctl_wr && in_range_c && (!fifo_full_c || pop_c);
  assign drop_range_c = ioctl_wr && !in_range_c;
  assign drop_full_c  = ioctl_wr && in_range_c && fifo_full_c && !pop_c;

  // FSM state register and hold counter
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= S_HOLD;
      cnt_q   <= HOLD_C;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: download overrides everything, HOLD counts down to RUN
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_entry_c = 1'b0;
    if (ioctl_download) begin
      state_d      = S_LOAD;
      load_entry_c = (state_q != S_LOAD);
    end else begin
      case (state_q)
        S_HOLD, S_HOLD2: begin
          if (rst_req) begin
            cnt_d = HOLD_C;
          end else if (cnt_q <= HOLD_W'(1)) begin
            cnt_d   = '0;
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q - HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (rst_req) begin
            state_d = S_HOLD;
            cnt_d   = HOLD_C;
          end
        end
        S_LOAD: begin
          state_d = S_DRAIN;
        end
        S_DRAIN: begin
          if (fifo_empty_c) begin
            state_d = S_HOLD2;
            cnt_d   = HOLD_C;
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = HOLD_C;
        end
      endcase
    end
  end

  // FIFO pointers, count, output stage and sticky flags next state
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dn_wr_d      = 1'b0;
    dn_addr_d    = dn_addr_q;
    dn_data_d    = dn_data_q;
    core_reset_d = (state_d != S_RUN);
    overflow_d   = (load_entry_c ? 1'b0 : overflow_q) | drop_full_c;
    addr_err_d   = (load_entry_c ? 1'b0 : addr_err_q) | drop_range_c;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      dn_wr_d   = 1'b1;
      dn_addr_d = mem_q[rd_ptr_q][23:8];
      dn_data_d = mem_q[rd_ptr_q][7:0];
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since count guards every read
  always_ff @(posedge clk_sys) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= {ioctl_addr[15:0], ioctl_dout};
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dn_wr_q      <= 1'b0;
      dn_addr_q    <= '0;
      dn_data_q    <= '0;
      core_reset_q <= 1'b1;
      overflow_q   <= 1'b0;
      addr_err_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dn_wr_q      <= dn_wr_d;
      dn_addr_q    <= dn_addr_d;
      dn_data_q    <= dn_data_d;
      core_reset_q <= core_reset_d;
      overflow_q   <= overflow_d;
      addr_err_q   <= addr_err_d;
    end
  end

`ifdef DL_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;

  // Running sum of accepted bytes, restarted on each download entry
  always_comb begin
    sum_d = load_entry_c ? 8'h00 : sum_q;
    if (push_c) begin
      sum_d = sum_d + ioctl_dout;
    end
  end

  // Checksum register
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign dl_sum = sum_q;
`else
  // No checksum datapath in this build
`endif

  // Wait leaves one slot of margin for the HPS sampling wait late
  assign ioctl_wait = (count_q >= WAIT_C);
  assign dn_wr      = dn_wr_q;
  assign dn_addr    = dn_addr_q;
  assign dn_data    = dn_data_q;
  assign core_reset = core_reset_q;
  assign overflow   = overflow_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_rom_dl_ctrl.sv
// Scoreboard bench for rom_dl_ctrl: expected dn_* writes are queued as
// writes are issued and checked by a separate negedge monitor.
module tb_rom_dl_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        rst_req;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dn_busy;
  logic        dn_wr;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        core_reset;
  logic        overflow;
  logic        addr_err;
`ifdef DL_CHECKSUM_EN
  logic [7:0]  dl_sum;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_dnwr   = 0;
  logic [23:0] sb[$];

  rom_dl_ctrl #(
    .FIFO_DEPTH (4),
    .ROM_SIZE   (40960),
    .HOLD_CYCLES(16)
  ) dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .rst_req       (rst_req),
    .ioctl_download(ioctl_download),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .dn_busy       (dn_busy),
    .dn_wr         (dn_wr),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .core_reset    (core_reset),
    .overflow      (overflow),
    .addr_err      (addr_err)
`ifdef DL_CHECKSUM_EN
    ,
    .dl_sum        (dl_sum)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every dn_wr pulse must match the head of the scoreboard
  always @(negedge clk_sys) begin
    logic [23:0] exp_e;
    if (reset === 1'b0 && dn_wr === 1'b1) begin
      n_dnwr++;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_dn_wr: got addr %0h data %0h expected no write", dn_addr, dn_data);
      end else begin
        exp_e = sb.pop_front();
        check("dn_write", 32'({dn_addr, dn_data}), 32'(exp_e));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wr(input logic [24:0] a, input logic [7:0] d, input bit acc);
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    if (acc) sb.push_back({a[15:0], d});
    @(posedge clk_sys);
    #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic measure(output int n);
    n = 0;
    while (core_reset === 1'b1 && n < 200) begin
      @(posedge clk_sys);
      #1;
      n++;
    end
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk_sys);
      #1;
      k++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n;
    int base;
    reset          = 1'b1;
    rst_req        = 1'b0;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    dn_busy        = 1'b0;

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_dn_wr", 32'(dn_wr), 32'd0);
    check("rst_dn_addr", 32'(dn_addr), 32'd0);
    check("rst_dn_data", 32'(dn_data), 32'd0);
    check("rst_ioctl_wait", 32'(ioctl_wait), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_addr_err", 32'(addr_err), 32'd0);
`ifdef DL_CHECKSUM_EN
    check("rst_dl_sum", 32'(dl_sum), 32'd0);
`endif

    // Power-on hold
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    measure(n);
    check("poweron_hold_cycles", 32'(n), 32'd16);
    check("poweron_no_dn_wr", 32'(n_dnwr), 32'd0);

    // 256-byte download, no stalls
    ioctl_download = 1'b1;
    idle(1);
    check("core_reset_in_load", 32'(core_reset), 32'd1);
    base = n_dnwr;
    for (int i = 0; i < 256; i++) wr(25'(i), 8'(i) ^ 8'h5A, 1'b1);
    ioctl_download = 1'b0;
    measure(n);
    check("dl256_release_cycles", 32'(n), 32'd18);
    check("dl256_queue_empty", 32'(sb.size()), 32'd0);
    check("dl256_pulses", 32'(n_dnwr - base), 32'd256);
    check("dl256_overflow", 32'(overflow), 32'd0);
`ifdef DL_CHECKSUM_EN
    check("dl256_sum", 32'(dl_sum), 32'h80);
`endif

    // Stall with back-to-back writes into a depth-4 FIFO
    ioctl_download = 1'b1;
    idle(1);
    dn_busy = 1'b1;
    base = n_dnwr;
    wr(25'h100, 8'hA0, 1'b1);
    wr(25'h101, 8'hA1, 1'b1);
    check("wait_after_2", 32'(ioctl_wait), 32'd0);
    wr(25'h102, 8'hA2, 1'b1);
    check("wait_after_3", 32'(ioctl_wait), 32'd1);
    wr(25'h103, 8'hA3, 1'b1);
    check("overflow_before_5th", 32'(overflow), 32'd0);
    wr(25'h104, 8'hA4, 1'b0);
    check("overflow_after_5th", 32'(overflow), 32'd1);
    check("wait_full", 32'(ioctl_wait), 32'd1);
    idle(2);
    check("no_wr_while_busy", 32'(n_dnwr - base), 32'd0);
    dn_busy = 1'b0;
    wait_drain("stall_drain");
    check("stall_pulses", 32'(n_dnwr - base), 32'd4);
    check("wait_after_drain", 32'(ioctl_wait), 32'd0);
`ifdef DL_CHECKSUM_EN
    check("stall_sum", 32'(dl_sum), 32'h86);
`endif
    ioctl_download = 1'b0;
    measure(n);
    check("stall_release_cycles", 32'(n), 32'd18);

    // Range check, with rst_req held during LOAD
    ioctl_download = 1'b1;
    idle(1);
    check("overflow_clear_on_load", 32'(overflow), 32'd0);
    check("addr_err_clear_on_load", 32'(addr_err), 32'd0);
    rst_req = 1'b1;
    base = n_dnwr;
    wr(25'd40960, 8'h77, 1'b0);
    check("addr_err_at_limit", 32'(addr_err), 32'd1);
    wr(25'h10000, 8'h78, 1'b0);
    idle(2);
    check("range_no_dn_wr", 32'(n_dnwr - base), 32'd0);
    wr(25'd40959, 8'h33, 1'b1);
    idle(1);
    rst_req = 1'b0;
    wait_drain("range_drain");
    check("range_pulses", 32'(n_dnwr - base), 32'd1);
    check("core_reset_rstreq_in_load", 32'(core_reset), 32'd1);
`ifdef DL_CHECKSUM_EN
    check("range_sum", 32'(dl_sum), 32'h33);
`endif
    ioctl_download = 1'b0;
    measure(n);
    check("range_release_cycles", 32'(n), 32'd18);

    // rst_req pulse in RUN
    check("run_core_reset", 32'(core_reset), 32'd0);
    rst_req = 1'b1;
    idle(1);
    rst_req = 1'b0;
    check("rstreq_asserts_reset", 32'(core_reset), 32'd1);
    measure(n);
    check("rstreq_hold_cycles", 32'(n), 32'd16);

    // Download re-asserted during HOLD2
    ioctl_download = 1'b1;
    idle(1);
    wr(25'h1FFFFFF, 8'h00, 1'b0);
    wr(25'd5, 8'h11, 1'b1);
    idle(3);
    ioctl_download = 1'b0;
    idle(4);
    check("hold2_core_reset", 32'(core_reset), 32'd1);
    check("hold2_addr_err_sticky", 32'(addr_err), 32'd1);
`ifdef DL_CHECKSUM_EN
    check("hold2_sum", 32'(dl_sum), 32'h11);
`endif
    ioctl_download = 1'b1;
    idle(1);
    check("reload_addr_err_clear", 32'(addr_err), 32'd0);
    check("reload_core_reset", 32'(core_reset), 32'd1);
`ifdef DL_CHECKSUM_EN
    check("reload_sum_clear", 32'(dl_sum), 32'h00);
`endif

    // Push into a full FIFO while it pops
    dn_busy = 1'b1;
    base = n_dnwr;
    for (int i = 0; i < 4; i++) wr(25'h200 + 25'(i), 8'hC0 + 8'(i), 1'b1);
    check("full_wait", 32'(ioctl_wait), 32'd1);
    dn_busy = 1'b0;
    wr(25'h204, 8'hC4, 1'b1);
    check("full_pushpop_overflow", 32'(overflow), 32'd0);
    wait_drain("full_drain");
    check("full_pulses", 32'(n_dnwr - base), 32'd5);
`ifdef DL_CHECKSUM_EN
    check("full_sum", 32'(dl_sum), 32'hCA);
`endif
    ioctl_download = 1'b0;
    measure(n);
    check("full_release_cycles", 32'(n), 32'd18);

    // Async reset mid-download discards buffered bytes
    ioctl_download = 1'b1;
    idle(1);
    dn_busy = 1'b1;
    base = n_dnwr;
    wr(25'h300, 8'h55, 1'b0);
    wr(25'h301, 8'h56, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check("async_rst_core_reset", 32'(core_reset), 32'd1);
    check("async_rst_wait", 32'(ioctl_wait), 32'd0);
    ioctl_download = 1'b0;
    dn_busy = 1'b0;
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    measure(n);
    check("async_rst_hold_cycles", 32'(n), 32'd16);
    idle(5);
    check("async_rst_no_dn_wr", 32'(n_dnwr - base), 32'd0);
    check("final_queue_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
